// File: rtl/msg_arbiter_pkg.sv
// Shared types and header layout for the message arbiter.
// Header word: {5'b0, parity, source[1:0], length[7:0]}.
package msg_arbiter_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_LATCH,
      S_HDR,
      S_READ,
      S_DRAIN
   } state_t;

   localparam int PAR_BIT      = 10;
   localparam int SRC_LSB      = 8;
   localparam int LEN_LSB      = 0;
   localparam int AFULL_MARGIN = 3;

   function automatic logic [15:0] mk_hdr(input logic par, input logic [1:0] src,
                                          input logic [7:0] len);
      logic [15:0] h;
      h                  = '0;
      h[PAR_BIT]         = par;
      h[SRC_LSB +: 2]    = src;
      h[LEN_LSB +: 8]    = len;
      return h;
   endfunction

endpackage

// File: rtl/msg_arbiter_rr_pick.sv
// Round-robin candidate picker: first set request bit at or after i_ptr, wrapping.
// Purely combinational.
module rr_pick #(
   parameter int N_SRC = 2,
   parameter int SRC_W = 2
) (
   input  logic [N_SRC-1:0] i_req,
   input  logic [SRC_W-1:0] i_ptr,
   output logic             o_vld,
   output logic [SRC_W-1:0] o_idx
);

   // Scan two laps so the wrap-around needs no modulo on i_ptr.
   always_comb begin
      o_vld = 1'b0;
      o_idx = '0;
      for (int k = 0; k < 2 * N_SRC; k++) begin
         if (!o_vld && (k >= int'(i_ptr)) && i_req[k % N_SRC]) begin
            o_vld = 1'b1;
            o_idx = SRC_W'(k % N_SRC);
         end
      end
   end

endmodule

// File: rtl/msg_arbiter.sv
// Arbitrates whole messages from N_SRC source FIFOs into one output FIFO.
// Header then len data words; reads pause while OUT_AFULL is high.
module msg_arbiter
   import msg_arbiter_pkg::*;
#(
   parameter int N_SRC = 2,
   parameter int SRC_W = 2
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [N_SRC-1:0]      SRC_EN,
   input  logic [N_SRC-1:0]      GOT_FULL_MESSAGE,
   input  logic [8*N_SRC-1:0]    MSG_LEN,
   input  logic [N_SRC-1:0]      PARITY_IN,
   input  logic [16*N_SRC-1:0]   FIFO_Q,
   output logic [N_SRC-1:0]      MSG_START,
   output logic [N_SRC-1:0]      RD_REQ,
   output logic [15:0]           OUT_DATA,
   output logic                  OUT_WR,
   input  logic                  OUT_AFULL,
   output logic                  BUSY
);

   state_t            r_state, w_state_nxt;
   logic [SRC_W-1:0]  r_ptr, r_gnt;
   logic [7:0]        r_len, r_cnt;
   logic              r_par, r_rd_d;

   logic              w_pick_vld;
   logic [SRC_W-1:0]  w_pick_idx;
   logic              w_start, w_rd, w_hdr_wr;
   logic [N_SRC-1:0]  w_gnt_oh;
   logic [7:0]        w_len_sel;
   logic              w_par_sel;
   logic [15:0]       w_fifo_sel;

   rr_pick #(.N_SRC(N_SRC), .SRC_W(SRC_W)) u_rr_pick (
      .i_req (SRC_EN & GOT_FULL_MESSAGE),
      .i_ptr (r_ptr),
      .o_vld (w_pick_vld),
      .o_idx (w_pick_idx)
   );

   always_comb begin
      w_gnt_oh   = '0;
      w_len_sel  = '0;
      w_par_sel  = 1'b0;
      w_fifo_sel = '0;
      for (int i = 0; i < N_SRC; i++) begin
         if (r_gnt == SRC_W'(i)) begin
            w_gnt_oh[i] = 1'b1;
            w_len_sel   = MSG_LEN[8*i +: 8];
            w_par_sel   = PARITY_IN[i];
            w_fifo_sel  = FIFO_Q[16*i +: 16];
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_rd        = 1'b0;
      w_hdr_wr    = 1'b0;
      case (r_state)
         S_IDLE:  if (w_pick_vld) w_state_nxt = S_START;
         S_START: begin
            w_start     = 1'b1;
            w_state_nxt = S_LATCH;
         end
         S_LATCH: w_state_nxt = S_HDR;
         S_HDR: begin
            if (!OUT_AFULL) begin
               w_hdr_wr    = 1'b1;
               w_state_nxt = (r_len != 8'd0) ? S_READ : S_DRAIN;
            end
         end
         S_READ: begin
            if (!OUT_AFULL) begin
               w_rd = 1'b1;
               if (8'(r_cnt + 8'd1) == r_len) w_state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state <= S_IDLE;
         r_ptr   <= '0;
         r_gnt   <= '0;
         r_len   <= '0;
         r_par   <= 1'b0;
         r_cnt   <= '0;
         r_rd_d  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_rd_d  <= w_rd;
         if (r_state == S_IDLE && w_pick_vld) r_gnt <= w_pick_idx;
         if (r_state == S_LATCH) begin
            r_len <= w_len_sel;
            r_par <= w_par_sel;
            r_cnt <= '0;
         end
         if (w_rd) r_cnt <= r_cnt + 8'd1;
         if (r_state == S_DRAIN)
            r_ptr <= (r_gnt == SRC_W'(N_SRC - 1)) ? '0 : r_gnt + 1'b1;
      end
   end

   // Header is written straight from HDR; data lands the cycle after its read request.
   always_comb begin
      OUT_DATA = '0;
      if (w_hdr_wr)    OUT_DATA = mk_hdr(r_par, 2'(r_gnt), r_len);
      else if (r_rd_d) OUT_DATA = w_fifo_sel;
   end

   assign OUT_WR    = w_hdr_wr | r_rd_d;
   assign MSG_START = w_start ? w_gnt_oh : '0;
   assign RD_REQ    = w_rd ? w_gnt_oh : '0;
   assign BUSY      = (r_state != S_IDLE);

endmodule

// File: tb/tb_msg_arbiter.sv
// Directed bench for msg_arbiter: stimulus pushes expected output words, a monitor pops and compares.
module tb_msg_arbiter;
   import msg_arbiter_pkg::*;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic [1:0]  SRC_EN = '0;
   logic [1:0]  GOT_FULL_MESSAGE = '0;
   logic [15:0] MSG_LEN = '0;
   logic [1:0]  PARITY_IN = '0;
   logic [31:0] FIFO_Q;
   logic [1:0]  MSG_START, RD_REQ;
   logic [15:0] OUT_DATA;
   logic        OUT_WR;
   logic        OUT_AFULL = 1'b0;
   logic        BUSY;

   always #5 CLK = ~CLK;

   msg_arbiter #(.N_SRC(2), .SRC_W(2)) dut (
      .CLK(CLK), .RST(RST), .SRC_EN(SRC_EN), .GOT_FULL_MESSAGE(GOT_FULL_MESSAGE),
      .MSG_LEN(MSG_LEN), .PARITY_IN(PARITY_IN), .FIFO_Q(FIFO_Q),
      .MSG_START(MSG_START), .RD_REQ(RD_REQ), .OUT_DATA(OUT_DATA),
      .OUT_WR(OUT_WR), .OUT_AFULL(OUT_AFULL), .BUSY(BUSY)
   );

   // Source FIFO model: non-showahead, data one cycle after the request.
   logic [15:0] mem [2][256];
   logic [15:0] q_r [2];
   int          rdp [2];
   logic        fifo_clr = 1'b0;

   always @(posedge CLK) begin
      for (int i = 0; i < 2; i++) begin
         if (fifo_clr) rdp[i] <= 0;
         else if (RD_REQ[i]) begin
            q_r[i] <= mem[i][rdp[i]];
            rdp[i] <= rdp[i] + 1;
         end
      end
   end
   assign FIFO_Q = {q_r[1], q_r[0]};

   int          total = 0;
   int          bad   = 0;
   logic [15:0] exp_q [$];
   int          wr_cnt = 0;
   int          rd_cnt [2] = '{0, 0};
   int          st_cnt [2] = '{0, 0};

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h @%0t", nm, act, want, $time);
      end
   endtask

   always @(negedge CLK) begin
      if (RST) begin
         check("onehot_strobes", 32'($countones(MSG_START | RD_REQ) <= 1), 32'd1);
         for (int i = 0; i < 2; i++) begin
            if (RD_REQ[i])    rd_cnt[i]++;
            if (MSG_START[i]) st_cnt[i]++;
         end
         if (OUT_WR) begin
            wr_cnt++;
            if (exp_q.size() == 0) check("unexpected_write", 32'(OUT_DATA), 32'hDEAD_0000);
            else check("out_data", 32'(OUT_DATA), 32'(exp_q.pop_front()));
         end
      end
   end

   task automatic wait_busy(input logic lvl, input int budget, input string nm);
      int n = 0;
      while (BUSY !== lvl && n < budget) begin
         @(negedge CLK);
         n++;
      end
      check(nm, 32'(BUSY), 32'(lvl));
   endtask

   task automatic fill(input int s, input logic [15:0] base);
      for (int k = 0; k < 256; k++) mem[s][k] = base + 16'(k);
   endtask

   task automatic clr_fifo();
      fifo_clr = 1'b1;
      @(posedge CLK);
      #1 fifo_clr = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RST = 1'b0;
      repeat (2) @(negedge CLK);
      RST = 1'b1;
   endtask

   int wr0, rd0, st0, st1, n, afull_wr, afull_rd;

   initial begin
      fill(0, 16'hA000);
      fill(1, 16'hB000);
      #1;
      check("rst_busy", 32'(BUSY), 0);
      check("rst_out_wr", 32'(OUT_WR), 0);
      check("rst_out_data", 32'(OUT_DATA), 0);
      check("rst_strobes", 32'({MSG_START, RD_REQ}), 0);
      do_reset();
      clr_fifo();

      // Single message, GFM dropped after grant.
      mem[0][0] = 16'h1111; mem[0][1] = 16'h2222; mem[0][2] = 16'h3333;
      wr0 = wr_cnt; rd0 = rd_cnt[0]; st0 = st_cnt[0];
      exp_q.push_back(16'h0403); exp_q.push_back(16'h1111);
      exp_q.push_back(16'h2222); exp_q.push_back(16'h3333);
      MSG_LEN[7:0] = 8'd3; PARITY_IN = 2'b01; SRC_EN = 2'b01; GOT_FULL_MESSAGE = 2'b01;
      wait_busy(1'b1, 20, "t1_busy");
      GOT_FULL_MESSAGE = 2'b00;
      wait_busy(1'b0, 50, "t1_idle");
      check("t1_starts", 32'(st_cnt[0] - st0), 1);
      check("t1_rd_reqs", 32'(rd_cnt[0] - rd0), 3);
      check("t1_writes", 32'(wr_cnt - wr0), 4);
      check("t1_q_empty", 32'(exp_q.size()), 0);

      // Round-robin between two always-ready sources.
      do_reset();
      fill(0, 16'hA000);
      clr_fifo();
      MSG_LEN = {8'd1, 8'd1}; PARITY_IN = 2'b00; SRC_EN = 2'b11;
      exp_q.push_back(16'h0001); exp_q.push_back(16'hA000);
      exp_q.push_back(16'h0101); exp_q.push_back(16'hB000);
      exp_q.push_back(16'h0001); exp_q.push_back(16'hA001);
      GOT_FULL_MESSAGE = 2'b11;
      for (int m = 0; m < 3; m++) begin
         wait_busy(1'b1, 20, "t2_busy");
         if (m == 2) GOT_FULL_MESSAGE = 2'b00;
         wait_busy(1'b0, 50, "t2_idle");
      end
      repeat (5) @(negedge CLK);
      check("t2_q_empty", 32'(exp_q.size()), 0);

      // Backpressure during READ.
      do_reset();
      fill(0, 16'hC000);
      clr_fifo();
      MSG_LEN = {8'd0, 8'd5}; SRC_EN = 2'b01;
      wr0 = wr_cnt; rd0 = rd_cnt[0];
      exp_q.push_back(16'h0005);
      for (int k = 0; k < 5; k++) exp_q.push_back(16'hC000 + 16'(k));
      GOT_FULL_MESSAGE = 2'b01;
      wait_busy(1'b1, 20, "t3_busy");
      GOT_FULL_MESSAGE = 2'b00;
      n = 0;
      for (int c = 0; c < 40 && n < 2; c++) begin
         @(negedge CLK);
         if (RD_REQ[0]) n++;
      end
      check("t3_saw_reads", 32'(n), 2);
      @(posedge CLK);
      #1 OUT_AFULL = 1'b1;
      afull_wr = 0; afull_rd = 0;
      repeat (10) begin
         @(negedge CLK);
         if (OUT_WR) afull_wr++;
         if (RD_REQ != 2'b00) afull_rd++;
      end
      @(posedge CLK);
      #1 OUT_AFULL = 1'b0;
      wait_busy(1'b0, 50, "t3_idle");
      check("t3_afull_rd", 32'(afull_rd), 0);
      check("t3_afull_wr", 32'(afull_wr), 1);
      check("t3_afull_margin", 32'(afull_wr < AFULL_MARGIN), 1);
      check("t3_rd_reqs", 32'(rd_cnt[0] - rd0), 5);
      check("t3_writes", 32'(wr_cnt - wr0), 6);
      check("t3_q_empty", 32'(exp_q.size()), 0);

      // Zero-length message on source 1.
      MSG_LEN = {8'd0, 8'd0}; SRC_EN = 2'b10;
      wr0 = wr_cnt; rd0 = rd_cnt[0] + rd_cnt[1];
      exp_q.push_back(16'h0100);
      GOT_FULL_MESSAGE = 2'b10;
      wait_busy(1'b1, 20, "t4_busy");
      GOT_FULL_MESSAGE = 2'b00;
      wait_busy(1'b0, 20, "t4_idle");
      check("t4_writes", 32'(wr_cnt - wr0), 1);
      check("t4_rd_reqs", 32'(rd_cnt[0] + rd_cnt[1] - rd0), 0);
      check("t4_q_empty", 32'(exp_q.size()), 0);

      // Saturated length, enable dropped mid-message.
      fill(0, 16'h5000);
      clr_fifo();
      MSG_LEN = {8'd0, 8'd254}; PARITY_IN = 2'b01; SRC_EN = 2'b01;
      wr0 = wr_cnt; rd0 = rd_cnt[0];
      exp_q.push_back(16'h04FE);
      for (int k = 0; k < 254; k++) exp_q.push_back(16'h5000 + 16'(k));
      GOT_FULL_MESSAGE = 2'b01;
      wait_busy(1'b1, 20, "t5_busy");
      GOT_FULL_MESSAGE = 2'b00;
      SRC_EN = 2'b00;
      wait_busy(1'b0, 400, "t5_idle");
      check("t5_rd_reqs", 32'(rd_cnt[0] - rd0), 254);
      check("t5_writes", 32'(wr_cnt - wr0), 255);
      check("t5_q_empty", 32'(exp_q.size()), 0);

      // Reset mid-message, then the pointer must restart at source 0.
      fill(0, 16'h6000);
      clr_fifo();
      MSG_LEN = {8'd0, 8'd6}; PARITY_IN = 2'b00; SRC_EN = 2'b01;
      exp_q.push_back(16'h0006); exp_q.push_back(16'h6000);
      GOT_FULL_MESSAGE = 2'b01;
      n = 0;
      for (int c = 0; c < 40 && n < 2; c++) begin
         @(negedge CLK);
         if (RD_REQ[0]) n++;
      end
      check("t6_saw_reads", 32'(n), 2);
      @(posedge CLK);
      #1 RST = 1'b0;
      #1;
      check("t6_rst_busy", 32'(BUSY), 0);
      check("t6_rst_out_wr", 32'(OUT_WR), 0);
      check("t6_rst_out_data", 32'(OUT_DATA), 0);
      check("t6_rst_strobes", 32'({MSG_START, RD_REQ}), 0);
      check("t6_q_empty", 32'(exp_q.size()), 0);
      MSG_LEN = '0; SRC_EN = 2'b11; GOT_FULL_MESSAGE = 2'b11;
      st0 = st_cnt[0]; st1 = st_cnt[1];
      exp_q.push_back(16'h0000);
      repeat (3) @(negedge CLK);
      RST = 1'b1;
      wait_busy(1'b1, 20, "t6_busy");
      GOT_FULL_MESSAGE = 2'b00;
      wait_busy(1'b0, 20, "t6_idle");
      check("t6_start_src0", 32'(st_cnt[0] - st0), 1);
      check("t6_start_src1", 32'(st_cnt[1] - st1), 0);
      repeat (5) @(negedge CLK);
      check("t6_q_empty_end", 32'(exp_q.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1);
   end

endmodule
